bcd_down_counter: RTL and testbench



---
 rtl/bcd_counter_pkg.sv | 21 ++
 rtl/bcd_digit_dec.sv | 24 ++
 rtl/bcd_down_counter.sv | 116 +++++++++++
 tb/tb_bcd_down_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared FSM state type, BCD constant and digit helpers for the BCD counters
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] bcd_saturate(input logic [3:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

   // Callers zero-extend to 16 bits, which covers the widest (4-digit) counter.
   function automatic logic is_zero(input logic [15:0] value);
      return (value == 16'd0);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational single-digit BCD decrementer with borrow chain
module bcd_digit_dec
   import bcd_counter_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       borrow_i,
   output logic [3:0] digit_o,
   output logic       borrow_o
);

   always_comb begin
      digit_o  = digit_i;
      borrow_o = 1'b0;
      if (borrow_i) begin
         if (digit_i == 4'd0) begin
            digit_o  = BCD_MAX;
            borrow_o = 1'b1;
         end else begin
            digit_o = digit_i - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown timer with expiry flag
// Optional auto-reload on expiry when BCD_DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module bcd_down_counter
   import bcd_counter_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   LoadValue,
   input  logic                  Count,
   input  logic                  Clear,
   output logic [4*DIGITS-1:0]   Value,
   output logic                  Running,
   output logic                  Done,
   output logic                  Expired
);

   localparam int W = 4 * DIGITS;

   state_t         state_q, state_d;
   logic [W-1:0]   value_q, value_d;
   logic           done_q, done_d;
   logic [W-1:0]   load_sat;
   logic [W-1:0]   dec_value;
   logic [DIGITS:0] borrow;

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
   logic [W-1:0]   reload_q, reload_d;
`endif

   assign borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign load_sat[4*g +: 4] = bcd_saturate(LoadValue[4*g +: 4]);

      bcd_digit_dec u_dec (
         .digit_i  (value_q[4*g +: 4]),
         .borrow_i (borrow[g]),
         .digit_o  (dec_value[4*g +: 4]),
         .borrow_o (borrow[g+1])
      );
   end

   // A borrow out of the top digit means Value is zero: never wrap to 9..9.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      done_d  = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      if (Clear) begin
         state_d = IDLE;
         value_d = '0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
         reload_d = '0;
`endif
      end else if (Load) begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
         reload_d = load_sat;
`endif
         if (is_zero(16'(load_sat))) begin
            value_d = '0;
            state_d = EXPIRED;
            done_d  = 1'b1;
         end else begin
            value_d = load_sat;
            state_d = RUN;
         end
      end else if ((state_q == RUN) && Count && !borrow[DIGITS]) begin
         value_d = dec_value;
         if (is_zero(16'(dec_value))) begin
            done_d = 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
            if (!is_zero(16'(reload_q))) begin
               value_d = reload_q;
            end else begin
               state_d = EXPIRED;
            end
`else
            state_d = EXPIRED;
`endif
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         value_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         done_q  <= done_d;
      end
   end

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   assign Value   = value_q;
   assign Done    = done_q;
   assign Running = (state_q == RUN);
   assign Expired = (state_q == EXPIRED);

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - directed and random checks of bcd_down_counter against a decimal model
module tb_bcd_down_counter;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset, Load, Count, Clear;
   logic [W-1:0]  LoadValue;
   logic [W-1:0]  Value;
   logic          Running, Done, Expired;

   int tests = 0;
   int fails = 0;

   // Model: plain decimal integer plus status flags.
   int m_val    = 0;
   int m_reload = 0;
   bit m_run    = 0;
   bit m_exp    = 0;
   bit m_done   = 0;

   bcd_down_counter #(.DIGITS(DIGITS)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Load      (Load),
      .LoadValue (LoadValue),
      .Count     (Count),
      .Clear     (Clear),
      .Value     (Value),
      .Running   (Running),
      .Done      (Done),
      .Expired   (Expired)
   );

   always #5 Clock = ~Clock;

   function automatic int sat_dec(input logic [W-1:0] lv);
      int r = 0;
      int p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         int d;
         d = int'(lv[4*k +: 4]);
         if (d > 9) d = 9;
         r += d * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model(input bit rst, input bit clr, input bit ld, input logic [W-1:0] lv, input bit cnt);
      int v;
      m_done = 0;
      if (rst || clr) begin
         m_val = 0; m_run = 0; m_exp = 0; m_reload = 0;
      end else if (ld) begin
         v = sat_dec(lv);
         m_reload = v;
         if (v == 0) begin
            m_val = 0; m_run = 0; m_exp = 1; m_done = 1;
         end else begin
            m_val = v; m_run = 1; m_exp = 0;
         end
      end else if (m_run && cnt) begin
         if (m_val == 1) begin
            m_done = 1;
            if (AUTO && m_reload != 0) begin
               m_val = m_reload;
            end else begin
               m_val = 0; m_run = 0; m_exp = 1;
            end
         end else begin
            m_val = m_val - 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit rst, input bit clr, input bit ld,
                       input logic [W-1:0] lv, input bit cnt);
      @(negedge Clock);
      Reset = rst; Clear = clr; Load = ld; LoadValue = lv; Count = cnt;
      model(rst, clr, ld, lv, cnt);
      @(posedge Clock);
      #1;
      check({tag, ".value"},   16'(Value),   16'(to_bcd(m_val)));
      check({tag, ".running"}, 16'(Running), 16'(m_run));
      check({tag, ".done"},    16'(Done),    16'(m_done));
      check({tag, ".expired"}, 16'(Expired), 16'(m_exp));
   endtask

   initial begin
      Reset = 1; Clear = 0; Load = 0; Count = 0; LoadValue = '0;

      step("reset0", 1, 0, 0, '0, 0);
      step("reset1", 1, 0, 0, '0, 1);
      check("reset.value_const", 16'(Value), 16'h0000);

      step("load12", 0, 0, 1, W'('h12), 1);
      for (int i = 0; i < 12; i++) step("cnt12", 0, 0, 0, '0, 1);
      if (!AUTO) check("expiry.expired_const", 16'(Expired), 16'h0001);
      step("cnt_exp", 0, 0, 0, '0, 1);
      step("cnt_exp", 0, 0, 0, '0, 1);

      step("load10", 0, 0, 1, W'('h10), 0);
      step("borrow", 0, 0, 0, '0, 1);
      check("borrow.value_const", 16'(Value), 16'h0009);
      step("hold", 0, 0, 0, '0, 0);

      step("loadAF", 0, 0, 1, W'('hAF), 0);
      check("sat.value_const", 16'(Value), 16'h0099);
      step("load00", 0, 0, 1, W'('h00), 1);
      step("after00", 0, 0, 0, '0, 1);

      step("load05", 0, 0, 1, W'('h05), 0);
      step("load30cnt", 0, 0, 1, W'('h30), 1);
      check("loadwins.value_const", 16'(Value), 16'h0030);
      step("clear", 0, 1, 1, W'('h44), 1);
      step("idlecnt", 0, 0, 0, '0, 1);

      step("load08", 0, 0, 1, W'('h08), 0);
      step("to07", 0, 0, 0, '0, 1);
      step("midreset", 1, 0, 1, W'('h55), 1);
      step("idlecnt2", 0, 0, 0, '0, 1);
      step("idlecnt3", 0, 0, 0, '0, 1);

      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] lv;
         int r;
         r  = int'($urandom_range(0, 99));
         lv = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
         step("rand", r < 2, (r >= 2) && (r < 5), (r >= 5) && (r < 15), lv,
              $urandom_range(0, 9) < 7);
      end

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      step("ar_load03", 0, 0, 1, W'('h03), 0);
      for (int i = 0; i < 9; i++) step("ar_cnt", 0, 0, 0, '0, 1);
      check("ar.value_const", 16'(Value), 16'h0003);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
